// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : FSM encoding (IDLE / REQ / WAIT)
//   NOP_INSTR     : canonical RV32 NOP (addi x0, x0, 0)
//   is_aligned    : word-alignment test on the two PC low bits
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus with a req/gnt/rvalid handshake.
//   o_req    : fetch unit requests a read of o_addr
//   o_addr   : word address, bits [1:0] always 0
//   i_gnt    : memory accepted the request this cycle
//   i_rvalid : i_rdata carries the response
//   i_rdata  : instruction word
// Signal prefixes are from the fetch unit's point of view.
interface fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            o_req;
  logic [XLEN-1:0] o_addr;
  logic            i_gnt;
  logic            i_rvalid;
  logic [XLEN-1:0] i_rdata;

  modport master (
    output o_req, o_addr,
    input  i_gnt, i_rvalid, i_rdata
  );

  modport slave (
    input  o_req, o_addr,
    output i_gnt, i_rvalid, i_rdata
  );

endinterface

// File: rtl/fetch_hold_reg.sv
// One-entry tagged hold register for the most recent fetch response.
//   clk, rst : clock, asynchronous active-high reset
//   i_load   : capture i_tag / i_data and mark the entry valid
//   i_tag    : word address the response belongs to
//   i_data   : response data
//   i_pc     : PC to compare against the stored tag
//   o_hit    : entry valid and tag equals i_pc
//   o_data   : stored data (visible whether or not it hits)
module fetch_hold_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_tag,
  input  logic [XLEN-1:0] i_data,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_hit,
  output logic [XLEN-1:0] o_data
);

  logic            r_v;
  logic [XLEN-1:0] r_tag;
  logic [XLEN-1:0] r_data;

  // NOTE: non-blocking assignments in clocked blocks, so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: tag and data are reset too, not just the valid bit: o_instr is
  // defined to read 0 out of reset, so this is not don't-care storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v    <= 1'b0;
      r_tag  <= '0;
      r_data <= '0;
    end else if (i_load) begin
      r_v    <= 1'b1;
      r_tag  <= i_tag;
      r_data <= i_data;
    end
  end

  // A stale response (PC moved on while in flight) simply fails this compare.
  assign o_hit  = r_v && (r_tag == i_pc);
  assign o_data = r_data;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage between the core PC and instruction memory.
//   clk, rst : clock, asynchronous active-high reset
//   i_pc     : current PC from the core
//   o_instr  : instruction word held for the last completed fetch
//   o_valid  : o_instr belongs to i_pc (core fetch-stall qualifier)
//   o_fault  : sticky; misaligned PC or response timeout, cleared by rst
//   bus      : fetch_unit_if master port to instruction memory
// Only one transaction is ever outstanding; the hold register's tag
// compare is what discards responses for a PC the core has left.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_instr,
  output logic            o_valid,
  output logic            o_fault,
  fetch_unit_if.master    bus
);

  localparam bit TO_EN = (RESP_TIMEOUT != 0);
  // Counter only has to reach RESP_TIMEOUT-1: the timeout fires on the
  // WAIT cycle that would make the count equal RESP_TIMEOUT.
  localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_req_addr;
  logic [TW-1:0]   r_tcnt;
  logic            r_fault;

  logic            w_hit;
  logic            w_misalign;
  logic            w_start;
  logic            w_resp;
  logic            w_timeout;

  assign w_misalign = !is_aligned(i_pc[1:0]);
  assign w_start    = (r_state == IDLE) && !r_fault && !w_hit && !w_misalign;
  assign w_resp     = (r_state == WAIT) && bus.i_rvalid;
  // A response landing on the last allowed cycle still wins over the timeout.
  assign w_timeout  = TO_EN && (r_state == WAIT) && !bus.i_rvalid &&
                      (r_tcnt == TW'(RESP_TIMEOUT - 1));

  fetch_hold_reg #(.XLEN(XLEN)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_resp),
    .i_tag  (r_req_addr),
    .i_data (bus.i_rdata),
    .i_pc   (i_pc),
    .o_hit  (w_hit),
    .o_data (o_instr)
  );

  assign o_valid = w_hit && !r_fault;
  assign o_fault = r_fault;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  // NOTE: default assignment first, so no path leaves w_state_nxt
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start)              w_state_nxt = REQ;
      REQ:     if (bus.i_gnt)            w_state_nxt = WAIT;
      WAIT:    if (w_resp || w_timeout)  w_state_nxt = IDLE;
      default:                           w_state_nxt = IDLE;
    endcase
  end

  // Outputs: address comes from the captured register, so a PC change
  // while in REQ never retracts or alters the in-flight request.
  always_comb begin
    bus.o_req  = (r_state == REQ);
    bus.o_addr = r_req_addr;
  end

  // Request address, WAIT-cycle counter, sticky fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_addr <= '0;
      r_tcnt     <= '0;
      r_fault    <= 1'b0;
    end else begin
      if (w_start) r_req_addr <= {i_pc[XLEN-1:2], 2'b00};

      if ((r_state == WAIT) && !w_resp && !w_timeout) r_tcnt <= r_tcnt + 1'b1;
      else                                            r_tcnt <= '0;

      if (w_timeout || ((r_state == IDLE) && w_misalign)) r_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int XLEN         = 32;
  localparam int RESP_TIMEOUT = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] i_pc = '0;
  logic [XLEN-1:0] o_instr;
  logic            o_valid;
  logic            o_fault;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(.XLEN(XLEN), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_pc    (i_pc),
    .o_instr (o_instr),
    .o_valid (o_valid),
    .o_fault (o_fault),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- memory model and delivery scoreboard ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0010: return 32'hAAAA_0001;
      32'h0000_003C: return NOP_INSTR;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  // Knobs for the memory responder.
  int          gnt_delay   = 0;   // REQ cycles without grant before gnt
  int          rsp_lat     = 1;   // cycles from gnt to rvalid (>=1)
  bit          drop        = 1'b0;
  bit          inject      = 1'b0;
  logic [31:0] inject_data = '0;

  // Scoreboard: the last response the memory actually delivered in WAIT.
  bit          delivered_v    = 1'b0;
  logic [31:0] delivered_addr = '0;
  bit          model_fault    = 1'b0;
  logic [31:0] txn_q[$];

  bit          m_pending   = 1'b0;
  int          m_req_wait  = 0;
  int          m_rsp_cnt   = 0;
  logic [31:0] m_pend_addr = '0;
  bit          m_resp_last = 1'b0;

  // The core sees a valid instruction exactly when the last delivered
  // response is for the PC it is presenting and no fault is pending.
  function automatic bit exp_valid();
    return delivered_v && (delivered_addr == i_pc) && !model_fault;
  endfunction

  // Memory responder: drives inputs 1 time unit after each rising edge.
  initial begin : responder
    bus.i_gnt    = 1'b0;
    bus.i_rvalid = 1'b0;
    bus.i_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_resp_last) begin
        delivered_v    = 1'b1;
        delivered_addr = m_pend_addr;
        m_resp_last    = 1'b0;
      end
      bus.i_gnt    = 1'b0;
      bus.i_rvalid = 1'b0;
      bus.i_rdata  = $urandom;
      if (rst) begin
        m_pending   = 1'b0;
        m_req_wait  = 0;
        delivered_v = 1'b0;
      end else if (inject) begin
        inject       = 1'b0;
        bus.i_rvalid = 1'b1;
        bus.i_rdata  = inject_data;
      end else if (m_pending) begin
        if (!drop) begin
          m_rsp_cnt--;
          if (m_rsp_cnt <= 0) begin
            bus.i_rvalid = 1'b1;
            bus.i_rdata  = mem_word(m_pend_addr);
            m_pending    = 1'b0;
            m_resp_last  = 1'b1;
          end
        end
      end else if (bus.o_req) begin
        if (m_req_wait >= gnt_delay) begin
          bus.i_gnt   = 1'b1;
          m_pending   = 1'b1;
          m_rsp_cnt   = rsp_lat;
          m_pend_addr = bus.o_addr;
          txn_q.push_back(bus.o_addr);
          m_req_wait  = 0;
        end else begin
          m_req_wait++;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.i_gnt && bus.i_rvalid))
      else begin
        errors++;
        $error("FAIL bus_gnt_rvalid: gnt and rvalid both high, required never");
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    i_pc        = '0;
    gnt_delay   = 0;
    rsp_lat     = 1;
    drop        = 1'b0;
    model_fault = 1'b0;
    repeat (2) cycle();
    txn_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      cycle();
      #1;
      if (o_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cycle();
    #1;
    checks++;
    if ({bus.o_req, bus.o_addr, o_valid, o_instr, o_fault} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b addr=%h valid=%b instr=%h fault=%b, required all 0",
               bus.o_req, bus.o_addr, o_valid, o_instr, o_fault);
    end
  endtask

  task automatic test_cold_fetch();
    do_reset();                 // cycle 0, i_pc = 0
    cycle(); #1;                // cycle 1
    checks++;
    if (bus.o_req !== 1'b1 || bus.o_addr !== 32'h0) begin
      errors++;
      $display("FAIL cold_req: req=%b addr=%h, required 1 / 00000000", bus.o_req, bus.o_addr);
    end
    cycle(); #1;                // cycle 2
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL cold_early_valid: got %b required 0", o_valid);
    end
    cycle(); #1;                // cycle 3
    checks++;
    if (o_valid !== 1'b1 || o_instr !== 32'h0050_0093) begin
      errors++;
      $display("FAIL cold_data: valid=%b instr=%h, required 1 / 00500093", o_valid, o_instr);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(); #1;
      checks++;
      if (bus.o_req !== 1'b0 || o_valid !== 1'b1) begin
        errors++;
        $display("FAIL cold_hold: req=%b valid=%b, required 0 / 1", bus.o_req, o_valid);
      end
    end
    checks++;
    if (txn_q.size() != 1) begin
      errors++;
      $display("FAIL cold_txn_count: got %0d required 1", txn_q.size());
    end
  endtask

  task automatic test_sequential();
    logic [31:0] pcs[3];
    bit ok;
    pcs = '{32'h0, 32'h4, 32'h8};
    do_reset();
    rsp_lat = 2;
    foreach (pcs[k]) begin
      i_pc = pcs[k];
      wait_valid(20, ok);
      checks++;
      if (!ok || o_instr !== mem_word(pcs[k])) begin
        errors++;
        $display("FAIL seq_data pc=%h: valid=%b instr=%h, required 1 / %h",
                 pcs[k], ok, o_instr, mem_word(pcs[k]));
      end
    end
    checks++;
    if (txn_q.size() != 3) begin
      errors++;
      $display("FAIL seq_txn_count: got %0d required 3", txn_q.size());
    end else begin
      foreach (pcs[k]) begin
        checks++;
        if (txn_q[k] !== pcs[k]) begin
          errors++;
          $display("FAIL seq_txn_addr[%0d]: got %h required %h", k, txn_q[k], pcs[k]);
        end
      end
    end
  endtask

  task automatic test_redirect();
    bit ok;
    do_reset();
    rsp_lat = 2;
    i_pc = 32'h10;              // cycle 0
    cycle();                    // cycle 1: REQ + gnt
    cycle();                    // cycle 2: WAIT
    i_pc = 32'h80;
    for (int i = 0; i < 2; i++) begin
      cycle(); #1;              // cycles 3, 4
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL redirect_stale_valid: got %b required 0", o_valid);
      end
    end
    checks++;
    if (o_instr !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL redirect_stale_data: got %h required aaaa0001", o_instr);
    end
    wait_valid(20, ok);
    checks++;
    if (!ok || o_instr !== mem_word(32'h80)) begin
      errors++;
      $display("FAIL redirect_new_data: valid=%b instr=%h, required 1 / %h",
               ok, o_instr, mem_word(32'h80));
    end
    checks++;
    if (txn_q.size() != 2 || txn_q[0] !== 32'h10 || txn_q[txn_q.size()-1] !== 32'h80) begin
      errors++;
      $display("FAIL redirect_txns: count=%0d last=%h, required 2 / 00000080",
               txn_q.size(), txn_q[txn_q.size()-1]);
    end
  endtask

  task automatic test_stall_hold();
    bit ok;
    do_reset();
    i_pc = 32'h20;
    wait_valid(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_fetch: o_valid got 0 required 1 within 20 cycles");
    end
    for (int i = 0; i < 10; i++) begin
      cycle(); #1;
      checks++;
      if (o_valid !== 1'b1 || bus.o_req !== 1'b0 || o_instr !== mem_word(32'h20)) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b req=%b instr=%h, required 1 / 0 / %h",
                 i, o_valid, bus.o_req, o_instr, mem_word(32'h20));
      end
    end
    checks++;
    if (txn_q.size() != 1) begin
      errors++;
      $display("FAIL stall_txn_count: got %0d required 1", txn_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    gnt_delay = 5;
    i_pc = 32'h40;              // cycle 0
    for (int i = 1; i <= 5; i++) begin
      cycle(); #1;
      checks++;
      if (bus.o_req !== 1'b1 || bus.o_addr !== 32'h40 || bus.i_gnt !== 1'b0) begin
        errors++;
        $display("FAIL bp_stable[%0d]: req=%b addr=%h gnt=%b, required 1 / 00000040 / 0",
                 i, bus.o_req, bus.o_addr, bus.i_gnt);
      end
      if (i == 2) i_pc = 32'h44;   // must not retract the in-flight 0x40
    end
    wait_valid(40, ok);
    checks++;
    if (!ok || o_instr !== mem_word(32'h44)) begin
      errors++;
      $display("FAIL bp_refetch: valid=%b instr=%h, required 1 / %h", ok, o_instr, mem_word(32'h44));
    end
    checks++;
    if (txn_q.size() != 2 || txn_q[0] !== 32'h40) begin
      errors++;
      $display("FAIL bp_txns: count=%0d first=%h, required 2 / 00000040", txn_q.size(), txn_q[0]);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    i_pc        = 32'h42;
    model_fault = 1'b1;
    cycle(); #1;
    checks++;
    if (o_fault !== 1'b1) begin
      errors++;
      $display("FAIL misalign_fault: got %b required 1", o_fault);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(); #1;
      checks++;
      if (bus.o_req !== 1'b0 || o_valid !== 1'b0 || o_fault !== 1'b1) begin
        errors++;
        $display("FAIL misalign_quiet: req=%b valid=%b fault=%b, required 0 / 0 / 1",
                 bus.o_req, o_valid, o_fault);
      end
    end
    checks++;
    if (txn_q.size() != 0) begin
      errors++;
      $display("FAIL misalign_txns: got %0d required 0", txn_q.size());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drop = 1'b1;
    i_pc = 32'h100;             // cycle 0; gnt cycle 1; WAIT cycles 2..5
    for (int i = 1; i <= 6; i++) begin
      cycle(); #1;
      checks++;
      if (o_fault !== (i == 6)) begin
        errors++;
        $display("FAIL timeout_fault cycle %0d: got %b required %b", i, o_fault, (i == 6));
      end
    end
    inject_data = 32'hBAD0_BAD0;
    inject      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(); #1;
      checks++;
      if (o_valid !== 1'b0 || o_instr !== 32'h0 || bus.o_req !== 1'b0 || o_fault !== 1'b1) begin
        errors++;
        $display("FAIL timeout_late_rsp: valid=%b instr=%h req=%b fault=%b, required 0 / 0 / 0 / 1",
                 o_valid, o_instr, bus.o_req, o_fault);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    i_pc = 32'h0;
    wait_valid(20, ok);
    checks++;
    if (!ok || o_instr !== 32'h0050_0093) begin
      errors++;
      $display("FAIL arst_prefetch: valid=%b instr=%h, required 1 / 00500093", ok, o_instr);
    end
    drop = 1'b1;
    i_pc = 32'h200;
    cycle();                    // REQ + gnt
    cycle(); #1;                // WAIT
    checks++;
    if (bus.o_addr !== 32'h200) begin
      errors++;
      $display("FAIL arst_inflight_addr: got %h required 00000200", bus.o_addr);
    end
    rst = 1'b1;                 // mid-cycle, away from the clock edge
    #1;
    checks++;
    if ({bus.o_req, bus.o_addr, o_valid, o_instr, o_fault} !== '0) begin
      errors++;
      $display("FAIL arst_outputs: req=%b addr=%h valid=%b instr=%h fault=%b, required all 0",
               bus.o_req, bus.o_addr, o_valid, o_instr, o_fault);
    end
    drop = 1'b0;
    cycle();
    rst         = 1'b0;
    inject_data = 32'hDEAD_BEEF;
    inject      = 1'b1;         // lands while the DUT sits in REQ
    cycle(); #1;
    cycle(); #1;
    checks++;
    if (o_instr !== 32'h0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_late_rsp: instr=%h valid=%b, required 00000000 / 0", o_instr, o_valid);
    end
    wait_valid(20, ok);
    checks++;
    if (!ok || o_instr !== mem_word(32'h200)) begin
      errors++;
      $display("FAIL arst_refetch: valid=%b instr=%h, required 1 / %h", ok, o_instr, mem_word(32'h200));
    end
  endtask

  task automatic test_random();
    int hold;
    bit ok;
    do_reset();
    for (int seg = 0; seg < 40; seg++) begin
      gnt_delay = $urandom_range(0, 3);
      rsp_lat   = $urandom_range(1, 2);
      hold      = $urandom_range(1, 6);
      cycle();
      i_pc = 32'($urandom_range(0, 15)) << 2;
      for (int c = 0; c < hold; c++) begin
        if (c != 0) cycle();
        #1;
        checks++;
        if (o_valid !== exp_valid()) begin
          errors++;
          $display("FAIL rand_valid seg=%0d pc=%h: got %b required %b", seg, i_pc, o_valid, exp_valid());
        end
        if (o_valid) begin
          checks++;
          if (o_instr !== mem_word(i_pc)) begin
            errors++;
            $display("FAIL rand_data seg=%0d pc=%h: got %h required %h", seg, i_pc, o_instr, mem_word(i_pc));
          end
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        wait_valid(30, ok);
        checks++;
        if (!ok || o_instr !== mem_word(i_pc)) begin
          errors++;
          $display("FAIL rand_settle seg=%0d pc=%h: valid=%b instr=%h, required 1 / %h",
                   seg, i_pc, ok, o_instr, mem_word(i_pc));
        end
      end
    end
  endtask

  initial begin : main
    test_reset();
    test_cold_fetch();
    test_sequential();
    test_redirect();
    test_stall_hold();
    test_backpressure();
    test_misalign();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the core pipeline.
- Watches the core's PC and runs a req/gnt/rvalid handshake to instruction memory, which may have variable grant and response latency.
- Returns the instruction word plus a valid flag that the core uses as its fetch-stall qualifier.
- Keeps a one-entry tagged hold register, so a PC held stable under stall re-hits without a new bus transaction, and responses for a stale PC (after a jump or branch redirect) are dropped naturally.

Parameters:
- XLEN, 32, data and address width of the PC and instruction word.
- RESP_TIMEOUT, 255, cycles in WAIT before o_fault asserts; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- i_pc  in  XLEN  current PC from core (core pcOut)
- o_instr  out  XLEN  instruction word for i_pc (core instr)
- o_valid  out  1  o_instr corresponds to the current i_pc (core ifValid)
- o_fault  out  1  sticky: misaligned PC or response timeout
- o_req  out  1  bus request
- o_addr  out  XLEN  bus word address, bits [1:0] forced to 0
- i_gnt  in  1  bus accepted request this cycle
- i_rvalid  in  1  read data valid
- i_rdata  in  XLEN  read data

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, o_req=0, o_addr=0, hold_v=0, hold_addr=0, hold_data=0, o_instr=0, o_valid=0, o_fault=0, timeout counter=0.
- o_valid is combinational: hold_v && hold_addr==i_pc && !o_fault.
- o_instr = hold_data at all times.
- State machine:
  - IDLE: if !o_valid and i_pc[1:0]==0 → REQ; next cycle o_req=1 and o_addr=i_pc sampled at the transition (captured into req_addr).
  - REQ: o_req and o_addr held stable until i_gnt. On i_gnt → WAIT; o_req deasserts the cycle after the grant. i_pc changing while in REQ does not alter the in-flight address (no retraction once asserted).
  - WAIT: on i_rvalid: hold_data<=i_rdata, hold_addr<=req_addr, hold_v<=1, → IDLE. If req_addr still equals i_pc, o_valid rises the cycle after i_rvalid.
  - Timeout: counter increments each WAIT cycle and clears on leaving WAIT. When count==RESP_TIMEOUT (nonzero) → o_fault=1, FSM → IDLE, and the late response is ignored.
- Minimum latency: PC change at cycle N → o_req at N+1 → gnt at N+1 → rvalid at N+2 → o_valid at N+3.
- Same-cycle gnt and rvalid is illegal on the bus; the bench asserts it never occurs.
- Stale response: the hold register loads with the old address; tag compare fails against the new i_pc, so o_valid stays 0 and IDLE immediately issues the new PC. No kill counter is needed (only one transaction is ever outstanding).
- Stall hit: i_pc unchanged while the core stalls → o_valid stays 1, no bus activity.
- Misaligned i_pc (bits[1:0]≠0) in IDLE → o_fault=1, no request issued.
- o_fault clears only on rst.
- i_rvalid outside WAIT is ignored.
- rst mid-transaction: all state drops immediately; a response arriving after reset deasserts is ignored (state is IDLE, not WAIT).

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2) and the instruction-word NOP constant 32'h00000013.
- Optional sub-module fetch_hold_reg: tag + data + valid, with load and compare; the FSM stays in fetch_unit.

Test Plan:
- Cold fetch: rst low at cycle 0, i_pc=0, memory gnt same cycle, rvalid 1 cycle later with 32'h00500093 → o_req high cycle 1, o_addr=0; o_valid=1 and o_instr=32'h00500093 at cycle 3; no further o_req while i_pc=0.
- Sequential stream: i_pc advances 0,4,8 each time o_valid=1, memory latency 2 → three bus transactions, one o_valid window per PC, o_instr matches memory contents at 0,4,8.
- Redirect mid-flight: request for 0x10 granted, i_pc changes to 0x80 before rvalid (data 0xAAAA0001) → o_valid stays 0, next request addresses 0x80, o_valid=1 with memory[0x80].
- Stall hold: i_pc=0x20 held 10 cycles after o_valid → o_valid stays 1, o_req stays 0 for all 10 cycles.
- Grant backpressure plus misalign: i_gnt held low 5 cycles → o_addr stable at 0x40 all 5 cycles; separately, i_pc=0x42 → o_fault=1, o_req never asserts.
- Timeout and async reset: RESP_TIMEOUT=4, no rvalid → o_fault=1 after 4 WAIT cycles; rst pulsed while in WAIT → every output reads 0 in the same cycle, and a late rvalid is ignored.
